// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with burst and lock hold.
// The grant never moves mid fixed-length burst or during a locked sequence.
module ahb_bus_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int MW             = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [N_MASTERS-1:0] HBUSREQ,
  input  logic [N_MASTERS-1:0] HLOCK,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HBURST,
  input  logic                 HREADY,
  output logic [N_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]        HMASTER,
  output logic                 HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [MW-1:0]        DEF_IDX   = MW'(DEFAULT_MASTER);
  localparam logic [N_MASTERS-1:0] DEF_GRANT = N_MASTERS'(1) << DEFAULT_MASTER;

  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]        master_q, master_d;
  logic                 mastlock_q, mastlock_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [MW-1:0]        last_q, last_d;

  logic [MW-1:0]        g_idx;
  logic [MW-1:0]        sel;
  logic                 found;
  logic                 owner_lock;
  logic                 hold;

  // Remaining beats after a NONSEQ; INCR and SINGLE never hold the bus.
  function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
    case (hburst)
      3'b010, 3'b011: burst_beats_m1 = 4'd3;
      3'b100, 3'b101: burst_beats_m1 = 4'd7;
      3'b110, 3'b111: burst_beats_m1 = 4'd15;
      default:        burst_beats_m1 = 4'd0;
    endcase
  endfunction

  always_comb begin
    g_idx = DEF_IDX;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) g_idx = MW'(i);
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = DEF_IDX;
    for (int i = 1; i <= N_MASTERS; i++) begin
      logic [MW-1:0] idx;
      idx = MW'((int'(last_q) + i) % N_MASTERS);
      if (!found && HBUSREQ[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (HREADY) begin
      case (HTRANS)
        TR_NONSEQ: cnt_d = burst_beats_m1(HBURST);
        TR_SEQ:    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        TR_IDLE:   cnt_d = 4'd0;
        TR_BUSY:   cnt_d = cnt_q;
        default:   cnt_d = cnt_q;
      endcase
    end
  end

  assign owner_lock = HLOCK[g_idx] & HBUSREQ[g_idx];
  assign hold       = (cnt_d != 4'd0) || owner_lock;

  always_comb begin
    grant_d    = grant_q;
    last_d     = last_q;
    master_d   = master_q;
    mastlock_d = mastlock_q;
    if (HREADY) begin
      // Address-phase ownership follows the grant one completed transfer later.
      master_d   = g_idx;
      mastlock_d = owner_lock;
      if (!hold) begin
        if (found) begin
          grant_d = N_MASTERS'(1) << sel;
          last_d  = sel;
        end else begin
          grant_d = DEF_GRANT;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q    <= DEF_GRANT;
      master_q   <= DEF_IDX;
      mastlock_q <= 1'b0;
      cnt_q      <= 4'd0;
      last_q     <= DEF_IDX;
    end else begin
      grant_q    <= grant_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mastlock_q;

endmodule
